// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial receiver.
// State encoding and the default word width.
package serial_rx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/shift_reg_n.sv
// WIDTH-bit shift register with enable, direction select and clears.
// Q_next exposes the post-shift value so the completed word can be captured.
module shift_reg_n #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             En,
    input  logic             Din,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_next
);

    assign Q_next = MSB_FIRST ? {Q[WIDTH-2:0], Din}
                              : {Din, Q[WIDTH-1:1]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Q <= '0;
        end else if (Clear) begin
            Q <= '0;
        end else if (En) begin
            Q <= Q_next;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Serial-to-parallel receiver with Valid/Ack handoff and sticky overrun.
// FSM, bit counter and output registers; the datapath is shift_reg_n.
module serial_receiver
    import serial_rx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             Shift_En,
    input  logic             Serial_In,
    input  logic             Ack,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Valid,
    output logic             Busy,
    output logic [CW-1:0]    Bit_Count,
    output logic             Overrun
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_t        state;
    logic             take;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_next;

    // A bit is accepted unless a word is held and not being acknowledged
    assign take = Shift_En && !Clear && (state != HOLD || Ack);

    shift_reg_n #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sreg (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Clear   (Clear),
        .En      (take),
        .Din     (Serial_In),
        .Q       (word),
        .Q_next  (word_next)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            Data_Out  <= '0;
            Valid     <= 1'b0;
            Busy      <= 1'b0;
            Bit_Count <= '0;
            Overrun   <= 1'b0;
        end else if (Clear) begin
            state     <= IDLE;
            Valid     <= 1'b0;
            Busy      <= 1'b0;
            Bit_Count <= '0;
            Overrun   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Shift_En) begin
                        state     <= SHIFT;
                        Busy      <= 1'b1;
                        Bit_Count <= CW'(1);
                    end
                end
                SHIFT: begin
                    if (Shift_En) begin
                        if (Bit_Count == LAST) begin
                            state     <= HOLD;
                            Data_Out  <= word_next;
                            Valid     <= 1'b1;
                            Busy      <= 1'b0;
                            Bit_Count <= '0;
                        end else begin
                            Bit_Count <= Bit_Count + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (Ack) begin
                        Valid <= 1'b0;
                        if (Shift_En) begin
                            state     <= SHIFT;
                            Busy      <= 1'b1;
                            Bit_Count <= CW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (Shift_En) begin
                        Overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    logic unused_word;
    assign unused_word = ^word;

endmodule
